// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the pipelined ALU.
// Codes 0000-0100 are kept from the older combinational 4-op ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLT  = 4'b1001,
    OP_SLTU = 4'b1010,
    OP_MUL  = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } alu_state_e;

  // Codes 1100-1111 are not assigned to any operation.
  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= 4'b1011;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// Only the low WIDTH bits are kept, which is also the correct two's-complement low half.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  logic [WIDTH-1:0] r_ma;
  logic [WIDTH-1:0] r_mb;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic             r_busy;
  logic             w_last;

  // Asserted during the final iteration; the accumulator is complete one edge later.
  assign w_last = r_busy && (r_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ma   <= '0;
      r_mb   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_ma   <= i_a;
      r_mb   <= i_b;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_mb[0]) begin
        r_acc <= r_acc + r_ma;
      end
      r_ma  <= r_ma << 1;
      r_mb  <= r_mb >> 1;
      r_cnt <= r_cnt + SHW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = w_last;
  assign o_product = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags; MUL runs on the iterative multiplier.
// Single-cycle ops stream at one per cycle; the output register honours writeback backpressure.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             op_err
);

  alu_state_e       r_state;
  alu_state_e       w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_z, r_n, r_c, r_v, r_err;

  logic             w_out_free, w_accept, w_is_mul;
  logic             w_load_single, w_load_mul, w_load;
  logic             w_mul_busy, w_mul_done;
  logic [WIDTH-1:0] w_product;
  logic [WIDTH-1:0] w_res, w_ld_res;
  logic [WIDTH:0]   w_sum;
  logic [SHW-1:0]   w_shamt;
  logic             w_c, w_v, w_err;

  assign w_out_free = !r_out_valid || out_ready;
  // Held low during reset so nothing upstream believes it was consumed.
  assign in_ready   = (r_state == S_IDLE) && w_out_free && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = (alu_op == OP_MUL);

  assign w_load_single = w_accept && !w_is_mul;
  assign w_load_mul    = (r_state == S_DONE) && w_out_free;
  assign w_load        = w_load_single || w_load_mul;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && w_is_mul),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (w_mul_busy),
    .o_done   (w_mul_done),
    .o_product(w_product)
  );

  assign w_shamt = b[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_sum = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = !is_legal_op(alu_op);
    case (alu_op_e'(alu_op))
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_SLL:  w_res = a << w_shamt;
      OP_SRL:  w_res = a >> w_shamt;
      OP_SRA:  w_res = $signed(a) >>> w_shamt;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, a < b};
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done || !w_mul_busy) w_state_nxt = S_DONE;
      S_DONE:  if (w_out_free) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ld_res = w_load_mul ? w_product : w_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_ld_res;
        r_z         <= (w_ld_res == '0);
        r_n         <= w_ld_res[WIDTH-1];
        r_c         <= w_load_mul ? 1'b0 : w_c;
        r_v         <= w_load_mul ? 1'b0 : w_v;
        r_err       <= w_load_mul ? 1'b0 : w_err;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign op_err    = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a streamed vector table plus multiply, stall and reset sequences.
module tb_alu_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int NV = 19;

  logic             clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, result;
  logic [3:0]       alu_op;
  logic             flag_z, flag_n, flag_c, flag_v, op_err;

  int n_checks = 0;
  int n_errors = 0;

  // flags ordered {err, z, n, c, v}
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flags;
  } vec_t;

  vec_t vt[NV];

  alu_pipe #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .op_err   (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_out();
    return {26'd0, out_valid, op_err, flag_z, flag_n, flag_c, flag_v, result};
  endfunction

  function automatic logic [63:0] exp_out(input logic [4:0] flags, input logic [31:0] res);
    return {26'd0, 1'b1, flags, res};
  endfunction

  task automatic run_mul(input string nm, input logic [31:0] ma, input logic [31:0] mb,
                         input logic [31:0] pr);
    int   lat;
    logic ir_low;
    in_valid = 1'b1; alu_op = 4'b1011; a = ma; b = mb;
    tick();
    // keep offering an ADD; it must not be taken while the multiply runs
    alu_op = 4'b0001; a = 32'h11; b = 32'h22;
    lat = 0;
    ir_low = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
      if (in_ready) ir_low = 1'b0;
    end
    in_valid = 1'b0;
    chk({nm, "_latency"}, 64'(lat), 64'd33);
    chk({nm, "_in_ready_low"}, {63'd0, ir_low}, 64'd1);
    chk({nm, "_result"}, pack_out(), exp_out(5'b00000, pr));
  endtask

  initial begin
    vt[0]  = '{4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b01010};
    vt[1]  = '{4'b0010, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b00011};
    vt[2]  = '{4'b1001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5'b00000};
    vt[3]  = '{4'b1000, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 5'b00100};
    vt[4]  = '{4'b0111, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 5'b00000};
    vt[5]  = '{4'b0110, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 5'b00100};
    vt[6]  = '{4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 5'b00000};
    vt[7]  = '{4'b0100, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 5'b00000};
    vt[8]  = '{4'b0101, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 5'b00000};
    vt[9]  = '{4'b1010, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 5'b01000};
    vt[10] = '{4'b0000, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 5'b01000};
    vt[11] = '{4'b0001, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b00101};
    vt[12] = '{4'b0010, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 5'b00100};
    vt[13] = '{4'b0010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 5'b01010};
    vt[14] = '{4'b1110, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 5'b11000};
    vt[15] = '{4'b1000, 32'h7FFF_FFFF, 32'h0000_0020, 32'h7FFF_FFFF, 5'b00000};
    vt[16] = '{4'b1001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 5'b01000};
    vt[17] = '{4'b1000, 32'hFFFF_FFF0, 32'h0000_0004, 32'hFFFF_FFFF, 5'b00100};
    vt[18] = '{4'b1100, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000, 5'b11000};

    // reset with in_valid high
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    alu_op = 4'b0001; a = 32'h1; b = 32'h2;
    tick();
    tick();
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset_outputs", pack_out(), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);

    // back-to-back stream: each result must appear one edge after its accept
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; alu_op = vt[i].op; a = vt[i].a; b = vt[i].b;
      tick();
      chk($sformatf("vec%0d", i), pack_out(), exp_out(vt[i].flags, vt[i].res));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", {63'd0, out_valid}, 64'd0);

    run_mul("mul1", 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    run_mul("mul2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    tick();
    chk("mul_drain", {63'd0, out_valid}, 64'd0);

    // backpressure: AND result stalls 5 cycles while an OR waits upstream
    in_valid = 1'b1; alu_op = 4'b0011; a = 32'hFF00_FF00; b = 32'h0F0F_0F0F;
    tick();
    chk("and_load", pack_out(), exp_out(5'b00000, 32'h0F00_0F00));
    out_ready = 1'b0; alu_op = 4'b0100; a = 32'h0; b = 32'h0;
    #1;
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall_hold%0d", k), pack_out(), exp_out(5'b00000, 32'h0F00_0F00));
      chk($sformatf("stall_ready%0d", k), {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("handoff_and_accept", pack_out(), exp_out(5'b01000, 32'h0000_0000));
    tick();
    chk("bp_drain", {63'd0, out_valid}, 64'd0);

    // reset in the middle of a multiply discards it
    in_valid = 1'b1; alu_op = 4'b1011; a = 32'h0000_0007; b = 32'h0000_0009;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midmul_reset_outputs", pack_out(), 64'd0);
    chk("midmul_reset_idle", {63'd0, in_ready}, 64'd1);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (out_valid) seen++;
      end
      chk("midmul_no_result", 64'(seen), 64'd0);
    end
    in_valid = 1'b1; alu_op = 4'b0001; a = 32'h2; b = 32'h3;
    tick();
    in_valid = 1'b0;
    chk("post_reset_add", pack_out(), exp_out(5'b00000, 32'h0000_0005));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
